// File: rtl/uart_bram_ctrl_if.sv
// Byte-stream and BRAM port bundle between the frame sequencer (master)
// and the UART receiver/transmitter plus BRAM (slave).
interface uart_bram_ctrl_if #(
  parameter int unsigned ADDR_W = 8
);
  logic [7:0]        rx_data;
  logic              rx_done;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic              tx_busy;
  logic              bram_en;
  logic              bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [7:0]        bram_din;
  logic [7:0]        bram_dout;

  modport master (
    input  rx_data, rx_done, tx_busy, bram_dout,
    output tx_data, tx_start, bram_en, bram_we, bram_addr, bram_din
  );

  modport slave (
    output rx_data, rx_done, tx_busy, bram_dout,
    input  tx_data, tx_start, bram_en, bram_we, bram_addr, bram_din
  );
endinterface

// File: rtl/uart_bram_ctrl.sv
// Frame sequencer: HDR CMD ADDR LEN [data] -> BRAM writes, or BRAM range -> UART tx.
// Optional write acknowledge byte is enabled by defining UART_BRAM_ACK_EN.
module uart_bram_ctrl #(
  parameter int unsigned ADDR_W      = 8,
  parameter logic [7:0]  HDR_BYTE    = 8'h55,
  parameter int unsigned TIMEOUT_CYC = 1000000,
  parameter logic [7:0]  ACK_BYTE    = 8'hAA
) (
  input  logic             clk,
  input  logic             rst_n,
  uart_bram_ctrl_if.master bus,
  output logic             busy,
  output logic             frame_err
);
  localparam int unsigned TW     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [7:0]  CMD_WR = 8'h01;
  localparam logic [7:0]  CMD_RD = 8'h02;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_LEN,
    S_WDATA,
    S_RD_REQ,
    S_RD_WAIT,
    S_TX_SEND,
    S_TX_WAIT
`ifdef UART_BRAM_ACK_EN
    , S_ACK
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, addr_inc;
  logic [8:0]        rem_q, rem_d;
  logic              is_wr_q, is_wr_d;
  logic [TW-1:0]     tout_q, tout_d;
  logic [1:0]        sub_q, sub_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              bram_en_q, bram_en_d;
  logic              bram_we_q, bram_we_d;
  logic [ADDR_W-1:0] bram_addr_q, bram_addr_d;
  logic [7:0]        bram_din_q, bram_din_d;
  logic              frame_err_q, frame_err_d;
  logic              tx_start_c;
  logic              timed, timeout_hit;

`ifndef UART_BRAM_ACK_EN
  logic unused_ack_byte;
  assign unused_ack_byte = ^ACK_BYTE;
`endif

  assign addr_inc = addr_q + ADDR_W'(1);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    is_wr_d     = is_wr_q;
    sub_d       = sub_q;
    tx_data_d   = tx_data_q;
    bram_en_d   = 1'b0;
    bram_we_d   = 1'b0;
    bram_addr_d = bram_addr_q;
    bram_din_d  = bram_din_q;
    frame_err_d = 1'b0;
    tx_start_c  = 1'b0;

    timed       = (state_q == S_CMD) || (state_q == S_ADDR) ||
                  (state_q == S_LEN) || (state_q == S_WDATA);
    tout_d      = (timed && !bus.rx_done) ? tout_q + TW'(1) : '0;
    timeout_hit = timed && !bus.rx_done && (tout_q == TW'(TIMEOUT_CYC - 1));

    case (state_q)
      S_IDLE: begin
        if (bus.rx_done && bus.rx_data == HDR_BYTE) state_d = S_CMD;
      end
      S_CMD: begin
        if (bus.rx_done) begin
          if (bus.rx_data == CMD_WR || bus.rx_data == CMD_RD) begin
            is_wr_d = (bus.rx_data == CMD_WR);
            state_d = S_ADDR;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_IDLE;
          end
        end
      end
      S_ADDR: begin
        if (bus.rx_done) begin
          addr_d  = ADDR_W'(bus.rx_data);
          state_d = S_LEN;
        end
      end
      S_LEN: begin
        if (bus.rx_done) begin
          rem_d = (bus.rx_data == 8'd0) ? 9'd256 : {1'b0, bus.rx_data};
          if (is_wr_q) begin
            state_d = S_WDATA;
          end else begin
            // read strobe is registered so it lines up with the RD_REQ cycle
            bram_en_d   = 1'b1;
            bram_addr_d = addr_q;
            state_d     = S_RD_REQ;
          end
        end
      end
      S_WDATA: begin
        if (bus.rx_done) begin
          bram_en_d   = 1'b1;
          bram_we_d   = 1'b1;
          bram_din_d  = bus.rx_data;
          bram_addr_d = addr_q;
          addr_d      = addr_inc;
          rem_d       = rem_q - 9'd1;
          if (rem_q == 9'd1) begin
`ifdef UART_BRAM_ACK_EN
            tx_data_d = ACK_BYTE;
            sub_d     = 2'd0;
            state_d   = S_ACK;
`else
            state_d   = S_IDLE;
`endif
          end
        end
      end
      S_RD_REQ:  state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        tx_data_d = bus.bram_dout;
        state_d   = S_TX_SEND;
      end
      S_TX_SEND: begin
        if (!bus.tx_busy) begin
          tx_start_c = 1'b1;
          sub_d      = 2'd0;
          state_d    = S_TX_WAIT;
        end
      end
      S_TX_WAIT: begin
        if (sub_q == 2'd0) begin
          sub_d = 2'd1;
        end else if (!bus.tx_busy) begin
          addr_d = addr_inc;
          rem_d  = rem_q - 9'd1;
          if (rem_q == 9'd1) begin
            state_d = S_IDLE;
          end else begin
            bram_en_d   = 1'b1;
            bram_addr_d = addr_inc;
            state_d     = S_RD_REQ;
          end
        end
      end
`ifdef UART_BRAM_ACK_EN
      // sub_q: 0 = wait to start, 1 = let tx_busy rise, 2 = wait for it to fall
      S_ACK: begin
        case (sub_q)
          2'd0: begin
            if (!bus.tx_busy) begin
              tx_start_c = 1'b1;
              sub_d      = 2'd1;
            end
          end
          2'd1:    sub_d = 2'd2;
          default: if (!bus.tx_busy) state_d = S_IDLE;
        endcase
      end
`endif
      default: state_d = S_IDLE;
    endcase

    if (timeout_hit) begin
      frame_err_d = 1'b1;
      state_d     = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      is_wr_q     <= 1'b0;
      tout_q      <= '0;
      sub_q       <= '0;
      tx_data_q   <= '0;
      bram_en_q   <= 1'b0;
      bram_we_q   <= 1'b0;
      bram_addr_q <= '0;
      bram_din_q  <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      is_wr_q     <= is_wr_d;
      tout_q      <= tout_d;
      sub_q       <= sub_d;
      tx_data_q   <= tx_data_d;
      bram_en_q   <= bram_en_d;
      bram_we_q   <= bram_we_d;
      bram_addr_q <= bram_addr_d;
      bram_din_q  <= bram_din_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.tx_data   = tx_data_q;
  assign bus.tx_start  = tx_start_c;
  assign bus.bram_en   = bram_en_q;
  assign bus.bram_we   = bram_we_q;
  assign bus.bram_addr = bram_addr_q;
  assign bus.bram_din  = bram_din_q;
  assign busy          = (state_q != S_IDLE);
  assign frame_err     = frame_err_q;
endmodule
